// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {IDLE, DWELL, GAP} scan_state_t;

  // Widest supported display is 8 digits; callers slice the low NDIG bits.
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  function automatic int timer_width(input int dwell_cyc, input int blank_cyc);
    int longest;
    longest = (dwell_cyc > blank_cyc) ? dwell_cyc : blank_cyc;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; zero is high while the count sits at 0.
module dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with anti-ghost gap.
// Optional leading-zero suppression when LZ_BLANK_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int DWELL_CYC = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NDIG-1:0]       digits,
  input  logic [NDIG-1:0]         dig_en,
  output logic [NDIG-1:0]         an,
  output logic [3:0]              nib,
  output logic [$clog2(NDIG)-1:0] dig_idx,
  output logic                    frame_start
);

  localparam int IW = $clog2(NDIG);
  localparam int TW = timer_width(DWELL_CYC, BLANK_CYC);
  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYC - 1);
  localparam logic [TW-1:0] BLANK_LD = TW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  scan_state_t       state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [3:0]        nib_q, nib_d;
  logic              fs_q, fs_d;
  logic              advance;
  logic              tmr_load, tmr_zero;
  logic [TW-1:0]     tmr_val;
  logic [NDIG-1:0]   lz_show;

  dwell_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .val  (tmr_val),
    .zero (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    fs_d     = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = DWELL_LD;
    advance  = 1'b0;
    if (!en) begin
      // Abandon the current slot entirely; the next enable restarts at digit 0.
      state_d  = IDLE;
      idx_d    = '0;
      tmr_load = 1'b1;
      tmr_val  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = DWELL;
          idx_d    = '0;
          shadow_d = digits;
          fs_d     = 1'b1;
          tmr_load = 1'b1;
        end
        DWELL: begin
          if (tmr_zero) begin
            if (BLANK_CYC > 0) begin
              state_d  = GAP;
              tmr_load = 1'b1;
              tmr_val  = BLANK_LD;
            end else begin
              advance = 1'b1;
            end
          end
        end
        GAP:     if (tmr_zero) advance = 1'b1;
        default: state_d = IDLE;
      endcase
      if (advance) begin
        state_d  = DWELL;
        tmr_load = 1'b1;
        tmr_val  = DWELL_LD;
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          shadow_d = digits;
          fs_d     = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  // Output decode works on next-state values so the registered outputs line up with the state.
  always_comb begin
    lz_show = '1;
`ifdef LZ_BLANK_EN
    begin
      logic seen_nz;
      seen_nz = 1'b0;
      for (int k = NDIG - 1; k > 0; k--) begin
        seen_nz    = seen_nz | (shadow_d[4*k +: 4] != 4'h0);
        lz_show[k] = seen_nz;
      end
    end
`endif
    an_d = ANODE_OFF[NDIG-1:0];
    if (state_d == DWELL && dig_en[idx_d] && lz_show[idx_d])
      an_d[idx_d] = 1'b0;
    nib_d = shadow_d[4*idx_d +: 4];
  end

  // NOTE: the shadow frame is a plain register, so it is reset with everything else to keep nib defined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= ANODE_OFF[NDIG-1:0];
      nib_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      nib_q    <= nib_d;
      fs_q     <= fs_d;
    end
  end

  assign an          = an_q;
  assign nib         = nib_q;
  assign dig_idx     = idx_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: one instance with a blank gap, one without.
module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int D    = 5;
`ifdef LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dig_en = 4'hF;
  logic [3:0]  an_a, nib_a, an_b, nib_b;
  logic [1:0]  idx_a, idx_b;
  logic        fs_a, fs_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(NDIG), .DWELL_CYC(D), .BLANK_CYC(2)) dut_a (
    .clk(clk), .rst(rst_n), .en(en), .digits(digits), .dig_en(dig_en),
    .an(an_a), .nib(nib_a), .dig_idx(idx_a), .frame_start(fs_a)
  );

  seg_scan_ctrl #(.NDIG(NDIG), .DWELL_CYC(D), .BLANK_CYC(0)) dut_b (
    .clk(clk), .rst(rst_n), .en(en), .digits(digits), .dig_en(dig_en),
    .an(an_b), .nib(nib_b), .dig_idx(idx_b), .frame_start(fs_b)
  );

  // Reference model: time since frame start plus the frame's latched digits.
  bit          m_act [2];
  int          m_t   [2];
  logic [15:0] m_sh  [2];
  int          m_b   [2] = '{2, 0};
  logic [3:0]  m_de;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual !== expected)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    else
      n_pass++;
  endtask

  function automatic bit lz_ok(input logic [15:0] sh, input int s);
    bit nz;
    nz = (sh >> (4 * s)) != 16'h0;
    return !LZ || s == 0 || nz;
  endfunction

  task automatic model_step();
    m_de = dig_en;
    for (int i = 0; i < 2; i++) begin
      if (!en) begin
        m_act[i] = 1'b0;
      end else if (!m_act[i]) begin
        m_act[i] = 1'b1;
        m_t[i]   = 0;
        m_sh[i]  = digits;
      end else begin
        m_t[i]++;
        if (m_t[i] % (NDIG * (D + m_b[i])) == 0) m_sh[i] = digits;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0;
      m_t[i]   = 0;
      m_sh[i]  = 16'h0;
    end
  endtask

  task automatic compare_dut(input int i);
    int p, s, pos;
    logic [3:0] e_an, e_nib, a_an, a_nib;
    logic [1:0] a_idx;
    logic       a_fs;
    p   = NDIG * (D + m_b[i]);
    s   = (m_t[i] % p) / (D + m_b[i]);
    pos = (m_t[i] % p) % (D + m_b[i]);
    e_an = 4'hF;
    if (m_act[i] && pos < D && m_de[s] && lz_ok(m_sh[i], s)) e_an[s] = 1'b0;
    e_nib = 4'((m_sh[i] >> (4 * s)) & 16'hF);
    a_an  = (i == 0) ? an_a  : an_b;
    a_nib = (i == 0) ? nib_a : nib_b;
    a_idx = (i == 0) ? idx_a : idx_b;
    a_fs  = (i == 0) ? fs_a  : fs_b;
    check((i == 0) ? "model_a.an" : "model_b.an", 32'(a_an), 32'(e_an));
    check((i == 0) ? "model_a.idx" : "model_b.idx", 32'(a_idx), m_act[i] ? s : 0);
    check((i == 0) ? "model_a.fs" : "model_b.fs", 32'(a_fs), 32'(m_act[i] && (m_t[i] % p) == 0));
    if (e_an != 4'hF)
      check((i == 0) ? "model_a.nib" : "model_b.nib", 32'(a_nib), 32'(e_nib));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_dut(0);
    compare_dut(1);
  endtask

  typedef struct {
    int         n;
    logic [3:0] an;
    logic [3:0] nib;
    logic [1:0] idx;
    bit         fs;
  } row_t;

  row_t seq1 [8];

  initial begin
    seq1[0] = '{5, 4'b1110, 4'h4, 2'd0, 1'b1};
    seq1[1] = '{2, 4'b1111, 4'h0, 2'd0, 1'b0};
    seq1[2] = '{5, 4'b1101, 4'h3, 2'd1, 1'b0};
    seq1[3] = '{2, 4'b1111, 4'h0, 2'd1, 1'b0};
    seq1[4] = '{5, 4'b1011, 4'h2, 2'd2, 1'b0};
    seq1[5] = '{2, 4'b1111, 4'h0, 2'd2, 1'b0};
    seq1[6] = '{5, 4'b0111, 4'h1, 2'd3, 1'b0};
    seq1[7] = '{2, 4'b1111, 4'h0, 2'd3, 1'b0};
    model_reset();

    // Reset state
    #12;
    check("rst.an_a", 32'(an_a), 32'hF);
    check("rst.an_b", 32'(an_b), 32'hF);
    check("rst.nib_a", 32'(nib_a), 0);
    check("rst.idx_a", 32'(idx_a), 0);
    check("rst.fs_a", 32'(fs_a), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    // Basic scan against the literal expected sequence
    en = 1'b1;
    digits = 16'h1234;
    dig_en = 4'hF;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < seq1[r].n; c++) begin
        tick();
        check("seq1.an", 32'(an_a), 32'(seq1[r].an));
        check("seq1.idx", 32'(idx_a), 32'(seq1[r].idx));
        check("seq1.fs", 32'(fs_a), 32'(seq1[r].fs && c == 0));
        if (seq1[r].an != 4'hF) check("seq1.nib", 32'(nib_a), 32'(seq1[r].nib));
      end
    end

    // Mid-frame digit change is held off until the next frame
    for (int k = 0; k < 30; k++) begin
      tick();
      if (m_t[0] % 28 == 21) check("frame.nib_hold", 32'(nib_a), 32'h1);
      if (m_t[0] % 28 == 0 && m_t[0] > 28) begin
        check("frame.nib_new", 32'(nib_a), 32'hD);
        check("frame.fs_new", 32'(fs_a), 1);
      end
      if (m_t[0] % 28 == 14) digits = 16'hABCD;
    end

    // Enable dropped mid-dwell of digit 1, then re-raised
    for (int k = 0; k < 40 && (m_t[0] % 28) != 9; k++) tick();
    check("en_drop.aligned", 32'(m_t[0] % 28), 9);
    en = 1'b0;
    tick();
    check("en_drop.an", 32'(an_a), 32'hF);
    check("en_drop.idx", 32'(idx_a), 0);
    en = 1'b1;
    tick();
    check("en_rise.fs", 32'(fs_a), 1);
    check("en_rise.an", 32'(an_a), 32'hE);
    for (int k = 0; k < 30; k++) tick();

    // Masked digits keep their slot timing
    dig_en = 4'b1010;
    for (int k = 0; k < 60; k++) tick();
    dig_en = 4'hF;

    // Asynchronous reset mid-scan
    for (int k = 0; k < 40 && an_a == 4'hF; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.an_a", 32'(an_a), 32'hF);
    check("async_rst.an_b", 32'(an_b), 32'hF);
    check("async_rst.idx_a", 32'(idx_a), 0);
    check("async_rst.nib_b", 32'(nib_b), 0);
    model_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) tick();

    // Leading zeros
    digits = 16'h0070;
    for (int k = 0; k < 60; k++) tick();
    digits = 16'h0000;
    for (int k = 0; k < 60; k++) tick();

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      if (en) begin
        if ($urandom_range(39) == 0) en = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(9) == 0)
        for (int n = 0; n < 4; n++) digits[4*n +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(7) == 0) dig_en = 4'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
